// File: rtl/pwm_duty_sequencer.sv
// Configuration controller for pwm_core: captures period/duty/step requests and
// applies them only at PWM period boundaries, immediately or as a per-period linear ramp.
module pwm_duty_sequencer #(
    parameter int WIDTH        = 16,
    parameter int RESET_PERIOD = 100
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_duty,
    input  logic [WIDTH-1:0] cfg_step,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] duty_out,
    output logic             period_start,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, WAIT_EDGE, RAMP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] sh_period_q, sh_period_d;
    logic [WIDTH-1:0] sh_target_q, sh_target_d;
    logic [WIDTH-1:0] sh_step_q, sh_step_d;
    logic             done_q, done_d;
    logic             boundary;
    logic             handshake;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] next_val;

    function automatic logic [WIDTH-1:0] min_f(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // One ramp increment toward t; the sum carries an extra bit so it saturates at t instead of wrapping.
    function automatic logic [WIDTH-1:0] step_f(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] t,
                                                input logic [WIDTH-1:0] s);
        logic [WIDTH:0] sum;
        sum = {1'b0, x} + {1'b0, s};
        if (x < t) begin
            return (sum > {1'b0, t}) ? t : sum[WIDTH-1:0];
        end else if (x > t) begin
            return ((x - t) > s) ? (x - s) : t;
        end else begin
            return t;
        end
    endfunction

    assign boundary     = (period_q == '0) || (cnt_q == period_q - WIDTH'(1));
    assign cfg_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign handshake    = cfg_valid && cfg_ready;
    assign period_start = (cnt_q == '0);
    assign period_out   = period_q;
    assign duty_out     = duty_q;
    assign done         = done_q;
    assign start_val    = min_f(duty_q, sh_period_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = boundary ? '0 : cnt_q + WIDTH'(1);
        period_d    = period_q;
        duty_d      = duty_q;
        sh_period_d = sh_period_q;
        sh_target_d = sh_target_q;
        sh_step_d   = sh_step_q;
        done_d      = 1'b0;
        next_val    = '0;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    sh_period_d = cfg_period;
                    sh_target_d = min_f(cfg_duty, cfg_period);
                    sh_step_d   = cfg_step;
                    state_d     = WAIT_EDGE;
                end
            end
            WAIT_EDGE: begin
                if (boundary) begin
                    period_d = sh_period_q;
                    if ((sh_step_q == '0) || (start_val == sh_target_q)) begin
                        next_val = sh_target_q;
                    end else begin
                        next_val = step_f(start_val, sh_target_q, sh_step_q);
                    end
                    duty_d = next_val;
                    if (next_val == sh_target_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RAMP;
                    end
                end
            end
            RAMP: begin
                if (boundary) begin
                    next_val = step_f(duty_q, sh_target_q, sh_step_q);
                    duty_d   = next_val;
                    if (next_val == sh_target_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= WIDTH'(RESET_PERIOD);
            duty_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            done_q   <= done_d;
        end
    end

    // Shadows are only consulted outside IDLE, so reset leaves them alone.
    always_ff @(posedge clk) begin
        sh_period_q <= sh_period_d;
        sh_target_q <= sh_target_d;
        sh_step_q   <= sh_step_d;
    end
endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Bench for pwm_duty_sequencer: a queue-based model of the update sequence checked
// every cycle, plus directed scenarios with literal expectations.
module tb_pwm_duty_sequencer;
    localparam int W = 16;
    typedef int int_q_t[$];

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_period = '0;
    logic [W-1:0] cfg_duty = '0;
    logic [W-1:0] cfg_step = '0;
    logic         cfg_ready, period_start, busy, done;
    logic [W-1:0] period_out, duty_out;

    int n_cmp = 0;
    int n_bad = 0;

    int     m_cnt = 0;
    int     m_period = 100;
    int     m_duty = 0;
    int     m_pend_period = 100;
    bit     m_done = 1'b0;
    int_q_t m_seq;
    int_q_t got_q;

    pwm_duty_sequencer #(.WIDTH(W), .RESET_PERIOD(100)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_step(cfg_step),
        .period_out(period_out), .duty_out(duty_out), .period_start(period_start),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every duty value the output will take, one per boundary, from start s to target t.
    function automatic int_q_t gen_seq(input int s, input int t, input int st);
        int_q_t q;
        int x;
        x = s;
        if (st == 0 || s == t) begin
            q.push_back(t);
            return q;
        end
        while (x != t) begin
            if (x < t) x = (x + st > t) ? t : x + st;
            else       x = (x - t > st) ? x - st : t;
            q.push_back(x);
        end
        return q;
    endfunction

    initial forever begin
        bit bnd;
        bit rdy;
        int nc;
        @(posedge clk or posedge reset_n);
        if (reset_n) begin
            m_cnt = 0; m_period = 100; m_duty = 0; m_done = 1'b0;
            m_seq.delete();
        end else begin
            bnd = (m_period == 0) || (m_cnt == m_period - 1);
            rdy = (m_seq.size() == 0);
            nc  = bnd ? 0 : m_cnt + 1;
            m_done = 1'b0;
            if (bnd && m_seq.size() > 0) begin
                m_period = m_pend_period;
                m_duty   = m_seq.pop_front();
                if (m_seq.size() == 0) m_done = 1'b1;
            end
            if (rdy && cfg_valid) begin
                m_pend_period = int'(cfg_period);
                m_seq = gen_seq((m_duty < int'(cfg_period)) ? m_duty : int'(cfg_period),
                                (cfg_duty < cfg_period) ? int'(cfg_duty) : int'(cfg_period),
                                int'(cfg_step));
            end
            m_cnt = nc;
        end
    end

    initial forever begin
        @(negedge clk);
        check("period_out", int'(period_out), m_period);
        check("duty_out", int'(duty_out), m_duty);
        check("period_start", int'(period_start), int'(m_cnt == 0));
        check("cfg_ready", int'(cfg_ready), int'(m_seq.size() == 0));
        check("busy", int'(busy), int'(m_seq.size() != 0));
        check("done", int'(done), int'(m_done));
    end

    task automatic send_cfg(input int p, input int d, input int s);
        int n;
        n = 0;
        cfg_period = W'(p); cfg_duty = W'(d); cfg_step = W'(s);
        cfg_valid  = 1'b1;
        while (!cfg_ready && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        if (!cfg_ready) check("hsk_timeout", 0, 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, input int exp_duty, input int exp_period);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max) begin
            @(negedge clk); n++;
        end
        if (done !== 1'b1) begin
            check("done_timeout", 0, 1);
        end else begin
            check("done_duty", int'(duty_out), exp_duty);
            check("done_period", int'(period_out), exp_period);
            check("done_with_ps", int'(period_start), 1);
            @(negedge clk);
            check("done_one_cycle", int'(done), 0);
        end
    endtask

    task automatic ramp_collect(input int max, input bit poke);
        int  prev;
        int  n;
        int  pk;
        bit  seen;
        prev = int'(duty_out); n = 0; pk = 0; seen = 1'b0;
        got_q.delete();
        while (n < max && !seen) begin
            @(negedge clk); n++;
            if (pk > 0) begin
                check("poke_ready", int'(cfg_ready), 0);
                pk--;
                if (pk == 0) cfg_valid = 1'b0;
            end
            if (int'(duty_out) != prev) begin
                got_q.push_back(int'(duty_out));
                prev = int'(duty_out);
                check("upd_on_ps", int'(period_start), 1);
                check("busy_in_ramp", int'(busy), done ? 0 : 1);
                if (poke && got_q.size() == 1 && !done) begin
                    cfg_period = W'(100); cfg_duty = W'(99); cfg_step = W'(0);
                    cfg_valid = 1'b1;
                    pk = 3;
                end
                if (done) seen = 1'b1;
            end
        end
        if (!seen) check("ramp_timeout", 0, 1);
    endtask

    initial begin
        int     n;
        int_q_t q;
        #1 reset_n = 1'b1;
        #2;
        check("rst_period", int'(period_out), 100);
        check("rst_duty", int'(duty_out), 0);
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;

        @(negedge clk);
        check("ps_after_rst", int'(period_start), 1);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!period_start && n < 300);
        check("ps_spacing100", n, 100);

        // immediate change
        send_cfg(100, 50, 0);
        wait_done(300, 50, 100);

        // ramp up 0 -> 30 by 10
        send_cfg(100, 0, 0);
        wait_done(300, 0, 100);
        q = gen_seq(0, 30, 10);
        check("model_up_len", q.size(), 3);
        if (q.size() == 3) begin
            check("model_up0", q[0], 10); check("model_up1", q[1], 20); check("model_up2", q[2], 30);
        end
        send_cfg(100, 30, 10);
        ramp_collect(1000, 1'b0);
        check("up_len", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("up0", got_q[0], 10); check("up1", got_q[1], 20); check("up2", got_q[2], 30);
        end

        // ramp down 30 -> 5 by 10, with an ignored request mid-ramp
        q = gen_seq(30, 5, 10);
        check("model_dn_len", q.size(), 3);
        if (q.size() == 3) begin
            check("model_dn0", q[0], 20); check("model_dn1", q[1], 10); check("model_dn2", q[2], 5);
        end
        send_cfg(100, 5, 10);
        ramp_collect(1000, 1'b1);
        check("dn_len", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("dn0", got_q[0], 20); check("dn1", got_q[1], 10); check("dn2", got_q[2], 5);
        end
        @(negedge clk);
        check("dn_still_5", int'(duty_out), 5);

        // clamp to period and period change, then period 0
        send_cfg(100, 80, 0);
        wait_done(300, 80, 100);
        send_cfg(40, 150, 0);
        wait_done(300, 40, 40);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!period_start && n < 200);
        check("ps_spacing40", n + 1, 40);
        send_cfg(0, 0, 0);
        wait_done(100, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ps_every_cycle", int'(period_start), 1);
        end

        // reset in the middle of a 0 -> 90 ramp
        send_cfg(100, 0, 0);
        wait_done(300, 0, 100);
        send_cfg(100, 90, 10);
        n = 0;
        while (duty_out != W'(10) && n < 300) begin
            @(negedge clk); n++;
        end
        check("mid_first_step", int'(duty_out), 10);
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b1;
        #1;
        check("async_period", int'(period_out), 100);
        check("async_duty", int'(duty_out), 0);
        check("async_ready", int'(cfg_ready), 1);
        check("async_busy", int'(busy), 0);
        check("async_ps", int'(period_start), 1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        check("ready_after_rel", int'(cfg_ready), 1);
        send_cfg(100, 25, 0);
        check("accept_first", int'(busy), 1);
        wait_done(300, 25, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pwm_duty_sequencer.md
# pwm_duty_sequencer

Configuration controller for `pwm_core`. It accepts a new period, target duty and ramp step through a valid/ready handshake, and drives `pwm_core`'s `period`/`duty` inputs. It applies changes only at PWM period boundaries, either immediately or as a per-period linear ramp toward the target, so the output never sees a truncated or mid-period-corrupted cycle. It sits between the register/host interface and `pwm_core`, tracking the PWM cycle with its own counter that starts from reset together with the core.

## Interface
- `WIDTH`, 16, width of period, duty, step and internal counter
- `RESET_PERIOD`, 100, value of `period_out` after reset
- `clk`  in  1  clock; all state is updated on the rising edge
- `reset_n`  in  1  reset, asynchronous, active-high
- `cfg_valid`  in  1  configuration request
- `cfg_ready`  out  1  high only in IDLE; a transfer occurs when `cfg_valid && cfg_ready` at a rising edge
- `cfg_period`  in  WIDTH  new PWM period in clk cycles
- `cfg_duty`  in  WIDTH  target high-time in clk cycles
- `cfg_step`  in  WIDTH  ramp increment per PWM period; 0 means an immediate change
- `period_out`  out  WIDTH  connects to `pwm_core.period`; registered
- `duty_out`  out  WIDTH  connects to `pwm_core.duty`; registered
- `period_start`  out  1  high in every cycle where `cnt == 0`
- `busy`  out  1  high in WAIT_EDGE and RAMP
- `done`  out  1  one-cycle pulse when `duty_out` reaches the target

## Operation
- Cycle counter `cnt`:
  - `boundary = (period_out == 0) || (cnt == period_out - 1)`.
  - `cnt <= boundary ? 0 : cnt + 1`.
- Shadow registers `sh_period`, `sh_duty`, `sh_step` are loaded on a handshake. Target `T = min(cfg_duty, cfg_period)`, computed at capture time.
- FSM states are IDLE, WAIT_EDGE and RAMP.
- IDLE:
  - `cfg_ready = 1`.
  - On a handshake, capture the shadows and go to WAIT_EDGE.
- WAIT_EDGE, at the first boundary:
  - `period_out <= sh_period`.
  - Start value `S = min(duty_out, sh_period)`.
  - If `sh_step == 0` or `S == T`: `duty_out <= T`, pulse `done`, go to IDLE.
  - Otherwise: `duty_out <= step(S)`. Go to IDLE with `done` if `step(S) == T`, else go to RAMP.
- RAMP, at each boundary:
  - `duty_out <= step(duty_out)`.
  - When the result equals T, pulse `done` and go to IDLE.
- `step(x)`:
  - If `x < T`: `min(x + sh_step, T)`.
  - If `x > T`: `x - sh_step` when `x - T > sh_step`, else `T`.
  - The addition is computed in WIDTH+1 bits, so there is no wrap-around; the ramp always saturates exactly at T.
- Configuration handling:
  - `cfg_ready = 0` in WAIT_EDGE and RAMP. `cfg_valid` in those states is ignored, not queued.
  - A handshake on the same edge as a boundary in IDLE still waits for the next boundary.
- Outputs change only at boundary edges. Between boundaries `period_out` and `duty_out` are stable.

## Timing
- Reset values, applied immediately on `reset_n = 1` regardless of clk:
  - `period_out = RESET_PERIOD`, `duty_out = 0`, `cnt = 0`.
  - State IDLE, `cfg_ready = 1`, `busy = 0`, `done = 0`.
- `period_start` is high in the first cycle after reset release.
- Timing of an update:
  - A new value is registered at the edge ending the cycle with `cnt == period_out - 1`.
  - It is therefore valid from the cycle in which `cnt == 0` and `period_start` is high.
- `done` is high in the same cycle as the final `duty_out` value, for exactly 1 cycle. `busy` falls in that same cycle.
- Latency:
  - Handshake to first update: at most `period_out` cycles (current period remainder).
  - Ramp of N steps: N boundaries.
- When `period_out == 0`, every cycle is a boundary, so updates apply on consecutive cycles.
- Reset mid-operation aborts the ramp, discards the shadows and returns all outputs to their reset values.

## Test plan
- **Reset:** drive reset_n high for 2 cycles, then release.
  - During reset: `period_out = 100`, `duty_out = 0`, `cfg_ready = 1`.
  - After release: `period_start` pulses every 100 cycles.
- **Immediate change:** `cfg_period = 100`, `cfg_duty = 50`, `cfg_step = 0`.
  - `duty_out = 50` first appears together with `period_start`, and `done` pulses once.
  - `pwm_core` then counts high = 50, low = 50 over the next period.
- **Ramp up:** from duty 0, `cfg_duty = 30`, `cfg_step = 10`.
  - `duty_out` is 10, 20, 30 on three successive `period_start` cycles.
  - `busy` is high throughout; `done` pulses with 30.
- **Ramp down with a non-multiple step:** from 30, `cfg_duty = 5`, `cfg_step = 10`.
  - `duty_out` goes 20, 10, 5.
  - A second `cfg_valid` during the ramp sees `cfg_ready = 0` and has no effect.
- **Clamp and period change:**
  - With duty 80, `cfg_period = 40`, `cfg_duty = 150`, `cfg_step = 0`: `period_out = 40` and `duty_out = 40` at the same boundary.
  - `cfg_period = 0`: `period_start` is high every cycle.
- **Reset mid-ramp:** assert reset_n between clock edges during a 0→90 ramp with step 10.
  - Outputs go to reset values before the next edge.
  - After release, a new configuration is accepted in the first cycle.
